// File: rtl/mult_seq_param.sv
// mult_seq_param: sequential A_WIDTH x B_WIDTH multiplier.
// One A_CHUNK x B_CHUNK partial product is formed and accumulated per clock,
// walking b's chunks (inner index j) for each chunk of a (outer index i).
// Optional feature macro MULT_SIGNED_EN adds an is_signed input selecting
// two's complement operands; without it all operands are unsigned.
module mult_seq_param #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
`ifdef MULT_SIGNED_EN
  input  logic                       is_signed,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int NA  = A_WIDTH / A_CHUNK;
  localparam int NB  = B_WIDTH / B_CHUNK;
  localparam int PW  = A_WIDTH + B_WIDTH;
  // Partial product width: both chunks carry one extra (sign) bit.
  localparam int PPW = A_CHUNK + B_CHUNK + 2;
  localparam int IW  = (NA > 1) ? $clog2(NA) : 1;
  localparam int JW  = (NB > 1) ? $clog2(NB) : 1;

  // Refuse to elaborate a geometry whose chunks do not tile the operands.
  if ((A_WIDTH % A_CHUNK) != 0) begin : gBadAChunk
    $error("mult_seq_param: A_WIDTH must be a multiple of A_CHUNK");
  end
  if ((B_WIDTH % B_CHUNK) != 0) begin : gBadBChunk
    $error("mult_seq_param: B_WIDTH must be a multiple of B_CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [A_WIDTH-1:0] aOp_q, aOp_d;
  logic [B_WIDTH-1:0] bOp_q, bOp_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [IW-1:0]   iIdx_q, iIdx_d;
  logic [JW-1:0]   jIdx_q, jIdx_d;

  logic            accept;
  logic            signedMode;
  logic            aLast, bLast;
  logic [A_CHUNK-1:0] aChunk;
  logic [B_CHUNK-1:0] bChunk;
  int              aOff, bOff;
  logic signed [A_CHUNK:0] aExt;
  logic signed [B_CHUNK:0] bExt;
  logic signed [PPW-1:0]   aWide, bWide, pp;
  logic [PW-1:0]   addend;

  // A new operation can only be taken while not in the middle of one.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef MULT_SIGNED_EN
  logic signed_q, signed_d;

  assign signed_d   = accept ? is_signed : signed_q;
  assign signedMode = signed_q;

  // Signedness is latched together with the operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signed_q <= 1'b0;
    end else begin
      signed_q <= signed_d;
    end
  end
`else
  assign signedMode = 1'b0;
`endif

  assign aLast = (iIdx_q == IW'(NA - 1));
  assign bLast = (jIdx_q == JW'(NB - 1));

  // Select the current chunk of a and its bit offset within the product.
  always_comb begin
    aChunk = '0;
    aOff   = 0;
    for (int k = 0; k < NA; k++) begin
      if (iIdx_q == IW'(k)) begin
        aChunk = aOp_q[k*A_CHUNK +: A_CHUNK];
        aOff   = k * A_CHUNK;
      end
    end
  end

  // Select the current chunk of b and its bit offset within the product.
  always_comb begin
    bChunk = '0;
    bOff   = 0;
    for (int k = 0; k < NB; k++) begin
      if (jIdx_q == JW'(k)) begin
        bChunk = bOp_q[k*B_CHUNK +: B_CHUNK];
        bOff   = k * B_CHUNK;
      end
    end
  end

  // Only the top chunk of each operand carries the sign; lower chunks are
  // plain magnitudes, so their extension bit is always zero.
  assign aExt  = {signedMode & aLast & aChunk[A_CHUNK-1], aChunk};
  assign bExt  = {signedMode & bLast & bChunk[B_CHUNK-1], bChunk};
  assign aWide = PPW'(aExt);
  assign bWide = PPW'(bExt);
  assign pp    = aWide * bWide;
  // Sign-extend (or truncate) to product width, then move to its weight.
  // Bits shifted past the top are dropped, giving modulo-2^PW accumulation.
  assign addend = PW'(pp) << (aOff + bOff);

  // Next-state, datapath update and Moore outputs of the controller.
  always_comb begin
    state_d = state_q;
    aOp_d   = aOp_q;
    bOp_d   = bOp_q;
    prod_d  = prod_q;
    iIdx_d  = iIdx_q;
    jIdx_d  = jIdx_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          aOp_d   = a;
          bOp_d   = b;
          prod_d  = '0;
          iIdx_d  = '0;
          jIdx_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        busy   = 1'b1;
        prod_d = prod_q + addend;
        if (bLast) begin
          jIdx_d = '0;
          if (aLast) begin
            iIdx_d  = '0;
            state_d = DONE;
          end else begin
            iIdx_d = iIdx_q + IW'(1);
          end
        end else begin
          jIdx_d = jIdx_q + JW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      aOp_q   <= '0;
      bOp_q   <= '0;
      prod_q  <= '0;
      iIdx_q  <= '0;
      jIdx_q  <= '0;
    end else begin
      state_q <= state_d;
      aOp_q   <= aOp_d;
      bOp_q   <= bOp_d;
      prod_q  <= prod_d;
      iIdx_q  <= iIdx_d;
      jIdx_q  <= jIdx_d;
    end
  end

  assign product = prod_q;

endmodule
